lii_tx_packer: RTL

Transmit-side LII link block: gathers narrow kernel output words (DW bits) into full PW-bit LII beats and drives one LII phy output channel, tagging each beat with src/dst IDs.
It is the packing counterpart of the kernel-side unpack wrappers, used when a kernel's stream is narrower than the phy.
It has a one-deep output register, so accumulation of beat N+1 overlaps draining of beat N.
An explicit flush emits a zero-padded partial beat.

---
 rtl/lii_pkg.sv | 13 +
 rtl/lii_out_reg.sv | 38 +++
 rtl/lii_tx_packer.sv | 116 +++++++++++
 3 files changed

// File: rtl/lii_pkg.sv
// Shared LII link definitions: ID width, default packing width and
// the lane-count width helper used by the packer and its output register.
package lii_pkg;

   localparam int LII_ID_W       = 8;
   localparam int LII_PW_DEFAULT = 1024;

   // nlanes must be able to hold the value K itself, hence K+1.
   function automatic int lane_cnt_w(input int k);
      return $clog2(k + 1);
   endfunction

endpackage

// File: rtl/lii_out_reg.sv
// One-deep valid/ready output register. A new beat may be loaded in the
// same cycle the held beat drains, so full throughput needs no bubble.
module lii_out_reg
   import lii_pkg::*;
#(
   parameter int PW  = LII_PW_DEFAULT,
   parameter int NLW = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic [PW-1:0]   load_data,
   input  logic [NLW-1:0]  load_nlanes,
   input  logic            tready,
   output logic            tvalid,
   output logic [PW-1:0]   tdata,
   output logic [NLW-1:0]  nlanes,
   output logic            free
);

   assign free = !tvalid | tready;

   // The caller only raises load when free is high.
   always_ff @(posedge clk) begin
      if (rst) begin
         tvalid <= 1'b0;
         tdata  <= '0;
         nlanes <= '0;
      end else if (load) begin
         tvalid <= 1'b1;
         tdata  <= load_data;
         nlanes <= load_nlanes;
      end else if (tready) begin
         tvalid <= 1'b0;
      end
   end

endmodule

// File: rtl/lii_tx_packer.sv
// Transmit-side LII packer: gathers DW-bit kernel words into PW-bit beats,
// with an explicit flush that emits a zero-padded partial beat.
module lii_tx_packer
   import lii_pkg::*;
#(
   parameter int                   DW     = 256,
   parameter int                   PW     = LII_PW_DEFAULT,
   parameter logic [LII_ID_W-1:0]  SRC_ID = 8'h00,
   parameter logic [LII_ID_W-1:0]  DST_ID = 8'h00
) (
   input  logic                              aclk,
   input  logic                              arst,
   input  logic [DW-1:0]                     s_tdata,
   input  logic                              s_tvalid,
   output logic                              s_tready,
   input  logic                              flush,
   output logic [PW-1:0]                     lii_out_p0_tdata,
   output logic                              lii_out_p0_tvalid,
   input  logic                              lii_out_p0_tready,
   output logic [LII_ID_W-1:0]               lii_out_p0_src,
   output logic [LII_ID_W-1:0]               lii_out_p0_dst,
   output logic [lane_cnt_w(PW/DW)-1:0]      lii_out_p0_nlanes,
   output logic                              ce
);

   localparam int K   = PW / DW;
   localparam int NLW = lane_cnt_w(K);
   localparam int CW  = $clog2(K);
   localparam logic [CW-1:0] LAST = CW'(K - 1);

   logic [CW-1:0]  cnt;
   logic [PW-1:0]  acc;
   logic           flush_pend;

   logic           out_free;
   logic           accept;
   logic           full_load;
   logic           flush_load;
   logic           load;
   logic [PW-1:0]  beat_data;
   logic [NLW-1:0] beat_nlanes;

   // out_free depends on tready combinationally, so s_tready does too.
   assign s_tready   = !flush_pend & ((cnt != LAST) | out_free);
   assign ce         = s_tready;
   assign accept     = s_tvalid & s_tready;
   assign full_load  = accept & (cnt == LAST);
   assign flush_load = flush_pend & (cnt != '0) & out_free;
   assign load       = full_load | flush_load;

   assign lii_out_p0_src = SRC_ID;
   assign lii_out_p0_dst = DST_ID;

   always_comb begin
      beat_data   = acc;
      beat_nlanes = NLW'(cnt);
      if (full_load) begin
         beat_data   = {s_tdata, acc[(K-1)*DW-1:0]};
         beat_nlanes = NLW'(K);
      end
   end

   always_ff @(posedge aclk) begin
      if (arst) begin
         cnt        <= '0;
         acc        <= '0;
         flush_pend <= 1'b0;
      end else if (flush_pend) begin
         // s_tready is low here, so no word can race the flush.
         if (cnt == '0) begin
            flush_pend <= 1'b0;
         end else if (out_free) begin
            acc        <= '0;
            cnt        <= '0;
            flush_pend <= 1'b0;
         end
      end else begin
         if (accept) begin
            if (cnt == LAST) begin
               acc <= '0;
               cnt <= '0;
            end else begin
               for (int i = 0; i < K; i++) begin
                  if (cnt == CW'(i)) acc[i*DW +: DW] <= s_tdata;
               end
               cnt <= cnt + CW'(1);
            end
         end
         // A flush arriving with the completing word is absorbed by that beat.
         if (flush && !full_load) flush_pend <= 1'b1;
      end
   end

   lii_out_reg #(
      .PW  (PW),
      .NLW (NLW)
   ) u_out_reg (
      .clk         (aclk),
      .rst         (arst),
      .load        (load),
      .load_data   (beat_data),
      .load_nlanes (beat_nlanes),
      .tready      (lii_out_p0_tready),
      .tvalid      (lii_out_p0_tvalid),
      .tdata       (lii_out_p0_tdata),
      .nlanes      (lii_out_p0_nlanes),
      .free        (out_free)
   );

`ifndef SYNTHESIS
   a_tdata_stable : assert property (@(posedge aclk) disable iff (arst)
      (s_tvalid && !s_tready) |=> $stable(s_tdata))
      else $error("s_tdata changed while stalled");
`endif

endmodule
